// File: rtl/frame_cfg_scheduler.sv
// frame_cfg_scheduler
// Arbitrates display-configuration updates from NREQ requesters and commits at
// most one of them per frame, only during vertical blanking, so the draw stages
// see a configuration word that is stable across every active frame. Also
// keeps a free-running count of frames started since reset.
//
// Ports:
//   pclk      in   pixel clock
//   rst       in   asynchronous active-high reset
//   vblnk_in  in   vertical blanking flag from the timing bus
//   req       in   [NREQ]        per-requester update request (level)
//   req_data  in   [NREQ*CFG_W]  requester i at bits [i*CFG_W +: CFG_W]
//   ack       out  [NREQ]        one-cycle one-hot grant pulse
//   cfg_out   out  [CFG_W]       committed configuration word
//                                ([11:0] background RGB 4:4:4, [15:12] layer enables)
//   cfg_upd   out  one-cycle strobe, high in the cycle cfg_out takes a new value
//   busy      out  high while arbitrating or applying
//   frame_cnt out  [FCNT_W]      frames started since reset (wraps)
module frame_cfg_scheduler #(
  parameter int              NREQ      = 3,
  parameter int              CFG_W     = 16,
  parameter logic [CFG_W-1:0] RESET_CFG = '0,
  parameter int              FCNT_W    = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vblnk_in,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CFG_W-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [CFG_W-1:0]      cfg_out,
  output logic                  cfg_upd,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_APPLY, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                vblnk_q, vblnk_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic                upd_q, upd_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CFG_W-1:0]    shadow_q, shadow_d;

  logic                vb_rise;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [CFG_W-1:0]    win_data;

  // vblnk_q resets to 1 so leaving reset mid-blank does not look like a new frame.
  assign vb_rise = vblnk_in & ~vblnk_q;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req[PTR_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    win_data = CFG_W'(req_data >> (int'(win_idx) * CFG_W));
  end

  always_comb begin
    state_d  = state_q;
    vblnk_d  = vblnk_in;
    ptr_d    = ptr_q;
    ack_d    = '0;
    cfg_d    = cfg_q;
    upd_d    = 1'b0;
    shadow_d = shadow_q;
    fcnt_d   = fcnt_q;
    if (vb_rise) fcnt_d = fcnt_q + FCNT_W'(1);
    case (state_q)
      S_IDLE: if (vb_rise) state_d = S_ARB;
      S_ARB: begin
        if (win_found) begin
          ack_d    = NREQ'(1) << win_idx;
          shadow_d = win_data;
          ptr_d    = win_idx;
          state_d  = S_APPLY;
        end else begin
          state_d = S_WAIT;
        end
      end
      // Runs to completion even if blanking has already ended.
      S_APPLY: begin
        cfg_d   = shadow_q;
        upd_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  if (!vblnk_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vblnk_q <= 1'b1;
      ptr_q   <= PTR_W'(NREQ - 1);
      ack_q   <= '0;
      cfg_q   <= RESET_CFG;
      upd_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vblnk_q <= vblnk_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      cfg_q   <= cfg_d;
      upd_q   <= upd_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Shadow is always written in ARB before APPLY reads it, so a reset leaves
  // nothing stale that could ever be committed.
  always_ff @(posedge pclk) begin
    shadow_q <= shadow_d;
  end

  assign ack       = ack_q;
  assign cfg_out   = cfg_q;
  assign cfg_upd   = upd_q;
  assign busy      = (state_q == S_ARB) || (state_q == S_APPLY);
  assign frame_cnt = fcnt_q;

endmodule
